// File: rtl/pic_hw_stack_pkg.sv
// Shared definitions for the PIC hardware return-address stack: command encodings and defaults.
package pic_hw_stack_pkg;

  typedef enum logic [1:0] {
    STK_NOP     = 2'd0,
    STK_PUSH    = 2'd1,
    STK_POP     = 2'd2,
    STK_REPLACE = 2'd3
  } stk_cmd_e;

  localparam int unsigned STK_PC_WIDTH_DEF = 11;
  localparam int unsigned STK_DEPTH_DEF    = 8;

endpackage

// File: rtl/pic_hw_stack_regfile.sv
// Return-address storage: DEPTH x PC_WIDTH, one synchronous write port, one asynchronous read port.
module stack_regfile #(
  parameter int PC_WIDTH = 11,
  parameter int DEPTH    = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [PC_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [PC_WIDTH-1:0] rdata_o
);

  logic [PC_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pic_hw_stack.sv
// PIC hardware return-address stack: pointer/count control around stack_regfile.
// Optional sticky overflow/underflow flags (ovf, unf) are built when STK_OVF_FLAG_EN is defined.
module pic_hw_stack
  import pic_hw_stack_pkg::*;
#(
  parameter int PC_WIDTH  = 11,
  parameter int DEPTH     = 8,
  parameter int WRAP_MODE = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          commandIn,
  input  logic [PC_WIDTH-1:0] in,
  output logic [PC_WIDTH-1:0] topOut,
  output logic [CW-1:0]       count,
  output logic                full,
`ifdef STK_OVF_FLAG_EN
  output logic                empty,
  output logic                ovf,
  output logic                unf
`else
  output logic                empty
`endif
);

  stk_cmd_e cmd;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec, waddr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_full, is_empty, we;
`ifdef STK_OVF_FLAG_EN
  logic          ovf_q, unf_q, ovf_evt, unf_evt;
`endif

  assign cmd      = stk_cmd_e'(commandIn);
  assign is_full  = (cnt_q == CW'(DEPTH));
  assign is_empty = (cnt_q == '0);
  // DEPTH is a power of two, so plain AW-bit arithmetic wraps modulo DEPTH.
  assign ptr_inc  = ptr_q + AW'(1);
  assign ptr_dec  = ptr_q - AW'(1);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    waddr = ptr_q;
`ifdef STK_OVF_FLAG_EN
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
`endif
    case (cmd)
      STK_PUSH, STK_REPLACE: begin
        if (cmd == STK_REPLACE && !is_empty) begin
          we = 1'b1;
        end else begin
`ifdef STK_OVF_FLAG_EN
          ovf_evt = is_full;
`endif
          if (!is_full || WRAP_MODE != 0) begin
            ptr_d = ptr_inc;
            waddr = ptr_inc;
            we    = 1'b1;
            if (!is_full) cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STK_POP: begin
`ifdef STK_OVF_FLAG_EN
        unf_evt = is_empty;
`endif
        if (!is_empty) begin
          ptr_d = ptr_dec;
          cnt_d = cnt_q - CW'(1);
        end else if (WRAP_MODE != 0) begin
          ptr_d = ptr_dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef STK_OVF_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_evt;
      unf_q <= unf_q | unf_evt;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`endif

  stack_regfile #(
    .PC_WIDTH(PC_WIDTH),
    .DEPTH   (DEPTH)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(in),
    .raddr_i(ptr_q),
    .rdata_o(topOut)
  );

  assign count = cnt_q;
  assign full  = is_full;
  assign empty = is_empty;

endmodule

// File: doc/pic_hw_stack.md
PIC_HW_STACK -- requirements
Module: pic_hw_stack

Interface
REQ-001 Parameter PC_WIDTH, default 11: width of each stored return address.
REQ-002 Parameter DEPTH, default 8: number of entries; legal values are powers of two from 2 to 64.
REQ-003 Parameter WRAP_MODE, default 1: 1 selects circular overwrite, 0 selects saturating, refusing behaviour.
REQ-004 Port clk  input  1  system clock, rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port commandIn  input  2  stack command: 0=NOP, 1=PUSH, 2=POP, 3=REPLACE.
REQ-007 Port in  input  PC_WIDTH  address to push or replace.
REQ-008 Port topOut  output  PC_WIDTH  entry at top-of-stack.
REQ-009 Port count  output  clog2(DEPTH)+1  number of valid entries.
REQ-010 Port full  output  1  high when count == DEPTH.
REQ-011 Port empty  output  1  high when count == 0.
REQ-012 Port ovf  output  1  sticky overflow flag; present only with STK_OVF_FLAG_EN.
REQ-013 Port unf  output  1  sticky underflow flag; present only with STK_OVF_FLAG_EN.

Function
REQ-014 The stack state (pointer, storage, count) SHALL update on the rising clk edge; topOut SHALL be combinational from registered state, so a result is visible in the cycle after the command.
REQ-015 PUSH SHALL advance the pointer by one modulo DEPTH, write `in` to the new top, and increment count.
REQ-016 POP SHALL retreat the pointer by one modulo DEPTH and decrement count; storage SHALL not be cleared.
REQ-017 REPLACE SHALL overwrite the top entry in place; pointer and count SHALL be unchanged.
REQ-018 REPLACE on empty SHALL behave as PUSH.
REQ-019 NOP SHALL hold all state.
REQ-020 PUSH when full with WRAP_MODE=1: the oldest entry SHALL be overwritten and count SHALL stay at DEPTH.
REQ-021 PUSH when full with WRAP_MODE=0: the command SHALL be ignored.
REQ-022 POP when empty with WRAP_MODE=1: the pointer SHALL still retreat, topOut SHALL show the stale entry, and count SHALL stay 0.
REQ-023 POP when empty with WRAP_MODE=0: the command SHALL be ignored.
REQ-024 Count arithmetic SHALL saturate at 0 and DEPTH and never wrap.
REQ-025 Pointer arithmetic SHALL wrap modulo DEPTH.

Reset
REQ-026 While rst_n is low, pointer, count, ovf and unf SHALL be 0 and full SHALL be 0.
REQ-027 While rst_n is low, empty SHALL be 1 and topOut SHALL be 0.
REQ-028 All storage entries SHALL reset to 0.
REQ-029 Reset asserted mid-command SHALL abandon the command, with no partial write.

Configuration
REQ-030 With macro STK_OVF_FLAG_EN defined, ovf SHALL set on PUSH when full and unf SHALL set on POP when empty, in either WRAP_MODE.
REQ-031 ovf and unf SHALL clear only on reset.
REQ-032 Without STK_OVF_FLAG_EN, the ovf and unf ports and their logic SHALL be absent.

Structure
REQ-033 Command encodings (STK_NOP, STK_PUSH, STK_POP, STK_REPLACE) SHALL live in the shared definitions header alongside the existing width macros.
REQ-034 Storage SHALL be a sub-module stack_regfile (DEPTH x PC_WIDTH, one write port, one asynchronous read port); pointer and count control SHALL stay in pic_hw_stack.

Verification
REQ-035 Reset, then PUSH 0x123, then PUSH 0x045 -> topOut 0x045 and count 2; POP -> topOut 0x123 and count 1.
REQ-036 DEPTH=8, WRAP_MODE=1: PUSH 0x001..0x009 -> count 8, full=1, topOut 0x009; eight POPs return 0x008..0x002, then 0x009 (wrapped); ovf=1 with macro.
REQ-037 WRAP_MODE=0, full with top 0x008: PUSH 0x0AA -> topOut 0x008, count 8; POP on empty -> count 0 and pointer unchanged; unf=1 with macro.
REQ-038 Count 3 with top 0x050: REPLACE 0x7FF -> topOut 0x7FF, count 3; REPLACE on empty -> count 1.
REQ-039 Assert rst_n low mid-PUSH 0x3FF asynchronously -> outputs reach their reset values immediately, no entry written; the next PUSH 0x011 gives count 1.
REQ-040 Alternating PUSH/POP for 100 cycles against a reference model -> topOut and count match every cycle for DEPTH=2 and DEPTH=64.
